param_seq_alu: RTL and testbench
================================

PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port in_valid  input  1  request present on A, B, Op.
REQ-005 Port in_ready  output  1  block can accept a request this cycle.
REQ-006 Port A  input  WIDTH  operand A, unsigned.
REQ-007 Port B  input  WIDTH  operand B, unsigned; also the shift amount.
REQ-008 Port Op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 shl, 100 shr, 101 and, 110 or, 111 xor.
REQ-009 Port out_valid  output  1  OUT and the flags hold a completed result.
REQ-010 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port OUT  output  2*WIDTH  result.
REQ-012 Port cb  output  1  carry (add) or borrow (sub); 0 for all other ops.
REQ-013 Port zero  output  1  high when OUT == 0.

Function
REQ-014 States: IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-015 Request accepted on a clock edge with in_valid && in_ready; A, B and Op are captured at acceptance and later input changes have no effect.
REQ-016 Non-mul op accepted in IDLE: result, cb and zero are registered at the same edge and the state goes to DONE, so out_valid is high in the first cycle after acceptance.
REQ-017 Mul accepted in IDLE: state goes to MUL and runs WIDTH shift-add iterations, one per cycle, then goes to DONE; out_valid is high exactly WIDTH+1 cycles after acceptance.
REQ-018 In DONE, OUT, cb, zero and out_valid are held stable until out_valid && out_ready; on that edge the state returns to IDLE and out_valid drops.
REQ-019 No overlap: a new request is accepted at the earliest one cycle after the handshake (in_ready is low in DONE); peak throughput is 1 op per 2 cycles.
REQ-020 add: OUT = zero-extended (A+B) mod 2^WIDTH; cb = carry out of bit WIDTH-1.
REQ-021 sub: OUT = zero-extended (A-B) mod 2^WIDTH; cb = 1 when A < B.
REQ-022 mul: OUT = full unsigned 2*WIDTH product; cb = 0.
REQ-023 shl/shr: logical shift of A by B; B >= WIDTH gives 0; result is confined to WIDTH bits and zero-extended; cb = 0.
REQ-024 and/or/xor: bitwise on WIDTH bits, zero-extended; cb = 0.
REQ-025 zero is computed from the final 2*WIDTH result.
REQ-026 In MUL, out_valid = 0 and in_ready = 0; in_valid and out_ready are ignored.

Reset
REQ-027 rst asserted at any time, including mid-MUL or in DONE, immediately forces state to IDLE and out_valid, OUT, cb and zero to 0; any in-flight operation is discarded.
REQ-028 in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-029 The first request can be accepted on the first rising edge after reset release.

Structure
REQ-030 Shared package alu_pkg holds the opcode enum (3-bit) and the state enum; WIDTH stays a module parameter.
REQ-031 Iterative multiplier is sub-module seq_multiplier (start, A, B -> done, product, WIDTH cycles); the remaining ops are combinational inside param_seq_alu.
REQ-032 No latches: every output is assigned on every path.

Verification (WIDTH=8)
REQ-033 add A=200, B=100, out_ready=1 -> out_valid one cycle after accept, OUT=0x002C, cb=1, zero=0.
REQ-034 sub A=5, B=10 -> OUT=0x00FB, cb=1; sub A=7, B=7 -> OUT=0, cb=0, zero=1.
REQ-035 mul A=255, B=255 -> out_valid exactly 9 cycles after accept, OUT=0xFE01, cb=0; in_ready low throughout.
REQ-036 shl A=0x81, B=1 -> OUT=0x0002; shr A=0xF0, B=9 -> OUT=0, zero=1.
REQ-037 Backpressure: xor A=0xAA, B=0x0F with out_ready=0 for 5 cycles -> OUT=0x00A5 held with out_valid high and in_ready low; state returns to IDLE one edge after out_ready rises.
REQ-038 Assert rst in cycle 4 of mul 3*4 -> all outputs 0 and in_ready high after release; a following add 1+1 returns OUT=0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and control-state encodings for the sequential ALU.
// Latency: none (types only).
// Backpressure: not applicable.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_SHL = 3'b011,
    OP_SHR = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier producing a full 2*WIDTH product.
// Latency: WIDTH iterations after start; done flags the cycle of the final iteration.
// Backpressure: none; the caller must capture product on the edge where done is high.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  // The last partial product is folded in combinationally so the caller can
  // register the finished product on the same edge as the final iteration.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = (cnt == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/param_seq_alu.sv
// Single-issue ALU: combinational ops finish at the accept edge, mul runs iteratively.
// Latency: 1 cycle for non-mul ops, WIDTH+1 cycles for mul.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         Op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] OUT,
  output logic               cb,
  output logic               zero
);

  localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH + 1)'(WIDTH);

  state_t             state;
  op_t                op_in;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               shift_oor;
  logic [WIDTH-1:0]   narrow;
  logic [2*WIDTH-1:0] res;
  logic               res_cb;

  assign op_in     = op_t'(Op);
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_in == OP_MUL);

  assign sum       = {1'b0, A} + {1'b0, B};
  assign diff      = {1'b0, A} - {1'b0, B};
  assign shift_oor = ({1'b0, B} >= SHIFT_LIMIT);

  // Non-mul results are WIDTH bits wide; diff's top bit is the borrow.
  always_comb begin
    narrow = '0;
    res_cb = 1'b0;
    case (op_in)
      OP_ADD: begin
        narrow = sum[WIDTH-1:0];
        res_cb = sum[WIDTH];
      end
      OP_SUB: begin
        narrow = diff[WIDTH-1:0];
        res_cb = diff[WIDTH];
      end
      OP_SHL:  narrow = shift_oor ? '0 : (A << B);
      OP_SHR:  narrow = shift_oor ? '0 : (A >> B);
      OP_AND:  narrow = A & B;
      OP_OR:   narrow = A | B;
      OP_XOR:  narrow = A ^ B;
      default: narrow = '0;
    endcase
    res = {{WIDTH{1'b0}}, narrow};
  end

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      OUT   <= '0;
      cb    <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_in == OP_MUL) begin
              state <= S_MUL;
            end else begin
              OUT   <= res;
              cb    <= res_cb;
              zero  <= (res == '0);
              state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            OUT   <= mul_product;
            cb    <= 1'b0;
            zero  <= (mul_product == '0);
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed bench for param_seq_alu at WIDTH=8 with hand-computed expectations.
// Latency: checks 1-cycle and 9-cycle result timing. Backpressure: holds out_ready low.
module tb_param_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  Op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] OUT;
  logic        cb;
  logic        zero;

  int checks;
  int passes;

  param_seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT),
    .cb        (cb),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request starting at a negedge; returns edges from accept to out_valid.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
    Op = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Op = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
    checks++; if ({OUT, cb, zero} !== 18'h0) $display("FAIL reset_outputs got OUT=%h cb=%b zero=%b want 0", OUT, cb, zero); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready); else passes++;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    do_op(3'b000, 8'd200, 8'd100, lat);
    checks++; if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat); else passes++;
    checks++; if ({OUT, cb, zero} !== {16'h002C, 1'b1, 1'b0}) $display("FAIL add_result got OUT=%h cb=%b zero=%b want 002c 1 0", OUT, cb, zero); else passes++;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL add_return_idle got valid=%b ready=%b want 0 1", out_valid, in_ready); else passes++;
  endtask

  task automatic test_sub();
    int lat;
    do_op(3'b001, 8'd5, 8'd10, lat);
    checks++; if ({OUT, cb, zero} !== {16'h00FB, 1'b1, 1'b0}) $display("FAIL sub_borrow got OUT=%h cb=%b zero=%b want 00fb 1 0", OUT, cb, zero); else passes++;
    @(negedge clk);
    do_op(3'b001, 8'd7, 8'd7, lat);
    checks++; if ({OUT, cb, zero} !== {16'h0000, 1'b0, 1'b1}) $display("FAIL sub_equal got OUT=%h cb=%b zero=%b want 0000 0 1", OUT, cb, zero); else passes++;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int  lat;
    logic ready_seen;
    ready_seen = 1'b0;
    Op = 3'b010; A = 8'd255; B = 8'd255; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Late input changes and a stray request must not disturb the captured operands.
    A = 8'd0; B = 8'd3; Op = 3'b000;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    checks++; if (lat !== 9) $display("FAIL mul_latency got %0d want 9", lat); else passes++;
    checks++; if ({OUT, cb, zero} !== {16'hFE01, 1'b0, 1'b0}) $display("FAIL mul_result got OUT=%h cb=%b zero=%b want fe01 0 0", OUT, cb, zero); else passes++;
    checks++; if (ready_seen !== 1'b0) $display("FAIL mul_in_ready got seen=%b want 0", ready_seen); else passes++;
    @(negedge clk);
    do_op(3'b010, 8'd13, 8'd11, lat);
    checks++; if (OUT !== 16'd143) $display("FAIL mul_small got %h want 008f", OUT); else passes++;
    @(negedge clk);
  endtask

  task automatic test_shift_logic();
    int lat;
    do_op(3'b011, 8'h81, 8'd1, lat);
    checks++; if ({OUT, cb} !== {16'h0002, 1'b0}) $display("FAIL shl_1 got OUT=%h cb=%b want 0002 0", OUT, cb); else passes++;
    @(negedge clk);
    do_op(3'b011, 8'h81, 8'd7, lat);
    checks++; if (OUT !== 16'h0080) $display("FAIL shl_7 got %h want 0080", OUT); else passes++;
    @(negedge clk);
    do_op(3'b100, 8'hF0, 8'd9, lat);
    checks++; if ({OUT, zero} !== {16'h0000, 1'b1}) $display("FAIL shr_oor got OUT=%h zero=%b want 0000 1", OUT, zero); else passes++;
    @(negedge clk);
    do_op(3'b100, 8'hF0, 8'd4, lat);
    checks++; if (OUT !== 16'h000F) $display("FAIL shr_4 got %h want 000f", OUT); else passes++;
    @(negedge clk);
    do_op(3'b101, 8'hF0, 8'h3C, lat);
    checks++; if (OUT !== 16'h0030) $display("FAIL and got %h want 0030", OUT); else passes++;
    @(negedge clk);
    do_op(3'b110, 8'hF0, 8'h3C, lat);
    checks++; if (OUT !== 16'h00FC) $display("FAIL or got %h want 00fc", OUT); else passes++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    bad = 0;
    out_ready = 1'b0;
    do_op(3'b111, 8'hAA, 8'h0F, lat);
    in_valid = 1'b1; A = 8'h11; B = 8'h22; Op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && OUT === 16'h00A5)) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else passes++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got valid=%b ready=%b want 0 1", out_valid, in_ready); else passes++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, OUT} !== {1'b1, 16'h0033}) $display("FAIL bp_next_add got valid=%b OUT=%h want 1 0033", out_valid, OUT); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    logic stray;
    stray = 1'b0;
    Op = 3'b010; A = 8'd3; B = 8'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready, OUT, cb, zero} !== 20'h0) $display("FAIL rst_mid_mul got valid=%b ready=%b OUT=%h cb=%b zero=%b want all 0", out_valid, in_ready, OUT, cb, zero); else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, OUT} !== {1'b1, 1'b0, 16'h0}) $display("FAIL rst_release got ready=%b valid=%b OUT=%h want 1 0 0000", in_ready, out_valid, OUT); else passes++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) $display("FAIL rst_no_stray got %b want 0", stray); else passes++;
    do_op(3'b000, 8'd1, 8'd1, lat);
    checks++; if ({lat == 1, OUT} !== {1'b1, 16'h0002}) $display("FAIL rst_then_add got lat=%0d OUT=%h want 1 0002", lat, OUT); else passes++;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_shift_logic();
    test_backpressure();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
